// File: rtl/mlp_host_seq.sv
// mlp_host_seq: autonomous initiator for the MLP accelerator slave port.
// Streams inputs/weights in, runs the network, polls DONE, returns result.
module mlp_host_seq #(
    parameter int N_INPUTS       = 2,
    parameter int N_HIDDEN       = 4,
    parameter int N_OUTPUT       = 1,
    parameter int IN_WIDTH       = 16,
    parameter int WGT_WIDTH      = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int SRC_WIDTH     = (IN_WIDTH > WGT_WIDTH) ? IN_WIDTH : WGT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error_timeout,
    output logic [OUT_WIDTH-1:0] result,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [SRC_WIDTH-1:0] src_data,
    output logic                 mlp_write_en,
    output logic [1:0]           mlp_addr,
    output logic [31:0]          mlp_writedata,
    input  logic [31:0]          mlp_readdata,
    input  logic                 mlp_irq
);

    localparam int N_HW = N_HIDDEN * (N_INPUTS + 1);
    localparam int N_OW = N_OUTPUT * (N_HIDDEN + 1);
    localparam int M1 = (N_HW > N_OW) ? N_HW : N_OW;
    localparam int M2 = (M1 > N_INPUTS) ? M1 : N_INPUTS;
    localparam int M3 = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
    localparam int CW = $clog2(M3 + 1);

    localparam logic [CW-1:0] LAST_IN = CW'(N_INPUTS - 1);
    localparam logic [CW-1:0] LAST_HW = CW'(N_HW - 1);
    localparam logic [CW-1:0] LAST_OW = CW'(N_OW - 1);
    localparam logic [CW-1:0] LAST_TO = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_IN   = 2'd1;
    localparam logic [1:0] A_WGT  = 2'd2;
    localparam logic [1:0] A_OUT  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LOAD_IN, S_LOAD_HW, S_SEL_OUT, S_LOAD_OW,
        S_GO, S_POLL, S_RD_ADDR, S_RD_CAP, S_ERR
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   armed, armed_n;
    logic                   wr_n, err_n;
    logic [1:0]             addr_n;
    logic [31:0]            data_n;
    logic [OUT_WIDTH-1:0]   res_n;
    logic                   hs;
    logic [31:0]            src_ext;
    logic                   unused_bits;

    assign unused_bits = ^{mlp_irq, mlp_readdata};
    assign src_ext     = 32'(signed'(src_data));
    assign busy        = (state != S_IDLE) && (state != S_ERR);
    assign done        = (state == S_RD_CAP);
    assign src_ready   = !mlp_write_en &&
                         (state inside {S_LOAD_IN, S_LOAD_HW, S_LOAD_OW});
    assign hs          = src_valid && src_ready;

    // State, bus registers and counters; bus values hold through gap cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            armed         <= 1'b0;
            mlp_write_en  <= 1'b0;
            mlp_addr      <= '0;
            mlp_writedata <= '0;
            error_timeout <= 1'b0;
            result        <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            armed         <= armed_n;
            mlp_write_en  <= wr_n;
            mlp_addr      <= addr_n;
            mlp_writedata <= data_n;
            error_timeout <= err_n;
            result        <= res_n;
        end
    end

    // Sequencer: a write is only issued when the previous strobe has dropped
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        armed_n = armed;
        wr_n    = 1'b0;
        addr_n  = mlp_addr;
        data_n  = mlp_writedata;
        err_n   = error_timeout;
        res_n   = result;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLR;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            S_CLR: begin
                if (!mlp_write_en) begin
                    wr_n    = 1'b1;
                    addr_n  = A_CTRL;
                    data_n  = 32'h0;
                    state_n = S_LOAD_IN;
                end
            end
            S_LOAD_IN: begin
                if (hs) begin
                    wr_n   = 1'b1;
                    addr_n = A_IN;
                    data_n = src_ext;
                    if (cnt == LAST_IN) begin
                        cnt_n   = '0;
                        state_n = S_LOAD_HW;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_LOAD_HW: begin
                if (hs) begin
                    wr_n   = 1'b1;
                    addr_n = A_WGT;
                    data_n = src_ext;
                    if (cnt == LAST_HW) begin
                        cnt_n   = '0;
                        state_n = S_SEL_OUT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_SEL_OUT: begin
                if (!mlp_write_en) begin
                    wr_n    = 1'b1;
                    addr_n  = A_CTRL;
                    data_n  = 32'h8;
                    state_n = S_LOAD_OW;
                end
            end
            S_LOAD_OW: begin
                if (hs) begin
                    wr_n   = 1'b1;
                    addr_n = A_WGT;
                    data_n = src_ext;
                    if (cnt == LAST_OW) begin
                        cnt_n   = '0;
                        state_n = S_GO;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_GO: begin
                if (!mlp_write_en) begin
                    wr_n   = 1'b1;
                    addr_n = A_CTRL;
                    data_n = 32'h1;
                end else if (mlp_addr == A_CTRL) begin
                    state_n = S_POLL;
                    armed_n = 1'b0;
                    cnt_n   = '0;
                end
            end
            S_POLL: begin
                if (!armed) begin
                    armed_n = 1'b1;
                end else if (mlp_readdata[1]) begin
                    state_n = S_RD_ADDR;
                    addr_n  = A_OUT;
                end else if (cnt == LAST_TO) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RD_ADDR: begin
                addr_n  = A_CTRL;
                state_n = S_RD_CAP;
            end
            S_RD_CAP: begin
                res_n   = mlp_readdata[OUT_WIDTH-1:0];
                state_n = S_IDLE;
            end
            S_ERR: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mlp_host_seq.sv
// tb_mlp_host_seq: vector table of inference runs against a slave model,
// write sequence scored through an expected-write queue.
module tb_mlp_host_seq;

    typedef struct {
        logic [15:0] in0;
        logic [15:0] in1;
        int          wbase;
        int          wstep;
        logic [15:0] outv;
        bit          nd;
        int          stall;
    } vec_t;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        error_timeout;
    logic [15:0] result;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] src_data;
    logic        mlp_write_en;
    logic [1:0]  mlp_addr;
    logic [31:0] mlp_writedata;
    logic [31:0] mlp_readdata;
    logic        mlp_irq;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int taken = 0;
    int stall_at = -1;
    int stall_left = 0;
    int cyc = 0;
    int run_cyc = 0;
    bit prev_we = 1'b0;
    bit never_done = 1'b0;
    logic [15:0] out_val = 16'h0;
    logic [15:0] last_res = 16'h0;
    int run_cnt = 0;
    logic s_done = 1'b0;

    logic [15:0] srcq[$];
    wr_t         expq[$];
    vec_t        vecs[4];

    mlp_host_seq #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .error_timeout(error_timeout),
        .result(result),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data(src_data),
        .mlp_write_en(mlp_write_en),
        .mlp_addr(mlp_addr),
        .mlp_writedata(mlp_writedata),
        .mlp_readdata(mlp_readdata),
        .mlp_irq(mlp_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Slave model: registered readdata, DONE ten cycles after RUN
    always @(posedge clk) begin
        if (mlp_write_en && mlp_addr == 2'd0) begin
            s_done  <= 1'b0;
            run_cnt <= mlp_writedata[0] ? 10 : 0;
        end else if (run_cnt > 0) begin
            run_cnt <= run_cnt - 1;
            if (run_cnt == 1 && !never_done) s_done <= 1'b1;
        end
        case (mlp_addr)
            2'd0:    mlp_readdata <= {30'b0, s_done, 1'b0};
            2'd3:    mlp_readdata <= {16'b0, out_val};
            default: mlp_readdata <= 32'h0;
        endcase
    end

    // Source stream driver with an optional seven-cycle stall
    initial begin
        src_valid = 1'b0;
        src_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (stall_left == 0 && stall_at >= 0 && taken == stall_at) begin
                stall_left = 7;
                stall_at   = -1;
            end
            if (stall_left > 0) begin
                stall_left--;
                src_valid = 1'b0;
            end else if (srcq.size() > 0) begin
                src_valid = 1'b1;
                src_data  = srcq[0];
            end else begin
                src_valid = 1'b0;
            end
            if (src_valid && src_ready) begin
                void'(srcq.pop_front());
                taken++;
            end
        end
    end

    // Bus monitor: scores each write against the expected queue
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (mlp_write_en) begin
            wr_seen++;
            chk("we_gap", {31'b0, prev_we}, 32'h0);
            if (expq.size() == 0) begin
                chk("wr_extra", {30'b0, mlp_addr}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", {30'b0, mlp_addr}, {30'b0, e.a});
                chk("wr_data", mlp_writedata, e.d);
            end
            if (mlp_addr == 2'd0 && mlp_writedata == 32'h1) run_cyc = cyc;
        end
        prev_we = mlp_write_en;
        if (done) done_seen++;
    end

    task automatic run(input vec_t v, input bit poke);
        int g;
        int d0;
        bit seen_err;
        bit poked;
        logic [15:0] w[17];
        seen_err = 1'b0;
        poked    = 1'b0;
        srcq.delete();
        expq.delete();
        for (int k = 0; k < 17; k++) w[k] = 16'(v.wbase + k * v.wstep);
        srcq.push_back(v.in0);
        srcq.push_back(v.in1);
        for (int k = 0; k < 17; k++) srcq.push_back(w[k]);
        expq.push_back('{2'd0, 32'h0});
        expq.push_back('{2'd1, {{16{v.in0[15]}}, v.in0}});
        expq.push_back('{2'd1, {{16{v.in1[15]}}, v.in1}});
        for (int k = 0; k < 12; k++)
            expq.push_back('{2'd2, {{16{w[k][15]}}, w[k]}});
        expq.push_back('{2'd0, 32'h8});
        for (int k = 12; k < 17; k++)
            expq.push_back('{2'd2, {{16{w[k][15]}}, w[k]}});
        expq.push_back('{2'd0, 32'h1});
        out_val    = v.outv;
        never_done = v.nd;
        stall_at   = v.stall;
        taken      = 0;
        wr_seen    = 0;
        d0         = done_seen;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        g = 0;
        do begin
            @(negedge clk); #1;
            g++;
            start = 1'b0;
            if (poke && wr_seen >= 17 && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (poke && done) start = 1'b1;
            if (error_timeout && !seen_err) begin
                seen_err = 1'b1;
                chk("poll_len", cyc - run_cyc, 18);
            end
        end while (busy && g < 3000);
        start = 1'b0;
        if (g >= 3000) chk("run_bound", g, 0);
        if (v.nd) begin
            chk("err_set", {31'b0, error_timeout}, 32'h1);
            chk("err_seen", {31'b0, seen_err}, 32'h1);
            chk("no_done", done_seen - d0, 0);
        end else begin
            last_res = v.outv;
            chk("err_clr", {31'b0, error_timeout}, 32'h0);
            chk("one_done", done_seen - d0, 1);
        end
        chk("result", {16'b0, result}, {16'b0, last_res});
        chk("busy_end", {31'b0, busy}, 32'h0);
        chk("wr_count", wr_seen, 22);
        chk("exp_left", expq.size(), 0);
        if (poke) begin
            repeat (30) @(negedge clk);
            #1;
            chk("poke_wr", wr_seen, 22);
            chk("poke_busy", {31'b0, busy}, 32'h0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
        chk({tag, "_err"}, {31'b0, error_timeout}, 32'h0);
        chk({tag, "_res"}, {16'b0, result}, 32'h0);
        chk({tag, "_rdy"}, {31'b0, src_ready}, 32'h0);
        chk({tag, "_we"}, {31'b0, mlp_write_en}, 32'h0);
        chk({tag, "_addr"}, {30'b0, mlp_addr}, 32'h0);
        chk({tag, "_wd"}, mlp_writedata, 32'h0);
    endtask

    initial begin
        int g;
        vecs[0] = '{16'hFF00, 16'h0200, 1, 1, 16'h0123, 1'b0, -1};
        vecs[1] = '{16'h0007, 16'hFFFF, 100, 3, 16'hFF80, 1'b0, 6};
        vecs[2] = '{16'h0003, 16'h0004, -16, 1, 16'h5555, 1'b1, -1};
        vecs[3] = '{16'h7FFF, 16'h8000, 1000, -7, 16'h4000, 1'b0, -1};
        start   = 1'b0;
        mlp_irq = 1'b0;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #1 check_zero("rst0");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run(vecs[i], 1'b0);

        run(vecs[0], 1'b1);

        srcq.delete();
        expq.delete();
        srcq.push_back(16'h0011);
        srcq.push_back(16'h0022);
        for (int k = 0; k < 17; k++) srcq.push_back(16'(k));
        expq.push_back('{2'd0, 32'h0});
        expq.push_back('{2'd1, 32'h11});
        wr_seen  = 0;
        stall_at = -1;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        g = 0;
        while (wr_seen < 2 && g < 200) begin
            @(negedge clk); #1;
            g++;
        end
        chk("rst_reach", {31'b0, (g < 200)}, 32'h1);
        chk("rst_busy_pre", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        #1 check_zero("rstmid");
        srcq.delete();
        expq.delete();
        last_res = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_seen = 0;
        repeat (20) @(negedge clk);
        #1;
        chk("post_rst_wr", wr_seen, 0);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        run(vecs[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
